ft245_device_model: RTL and testbench
=====================================

Name: ft245_device_model

Overview:
- Synthesizable responder for the FT2232H asynchronous 245-FIFO bus: it plays the FTDI chip against our ft245 master logic.
- Used for board-less simulation and for an on-FPGA loopback build, in which the master-side bus pins connect to this block instead of package pins.
- The host side is two AXI-stream ports:
  - s_axis carries bytes "sent by the PC" out on the bus.
  - m_axis carries bytes the master wrote.

Parameters:
- DEPTH, 16: entries in each of the RX and TX byte FIFOs; power of two, ≥2.
- RD_LATENCY, 3: cycles from synchronized rd_n fall to ft_d_oe/data valid; ≥1.
- RXF_PRECHARGE, 4: cycles rxf_n is forced high after each read.
- TXE_PRECHARGE, 4: cycles txe_n is forced high after each write.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- ft_rd_n, in, 1: read strobe from the master.
- ft_wr_n, in, 1: write strobe from the master.
- ft_siwu_n, in, 1: send-immediate strobe from the master.
- ft_d_in, in, 8: bus value driven by the master.
- ft_d_out, out, 8: bus value this block drives.
- ft_d_oe, out, 1: this block is driving the bus.
- ft_rxf_n, out, 1: low = byte available for the master.
- ft_txe_n, out, 1: low = space available for a master write.
- s_axis_tdata, in, 8: PC→FPGA byte.
- s_axis_tvalid, in, 1: PC→FPGA handshake valid.
- s_axis_tready, out, 1: PC→FPGA handshake ready.
- m_axis_tdata, out, 8: FPGA→PC byte.
- m_axis_tvalid, out, 1: FPGA→PC handshake valid.
- m_axis_tready, in, 1: FPGA→PC handshake ready.
- rx_level, out, $clog2(DEPTH+1): RX FIFO occupancy.
- tx_level, out, $clog2(DEPTH+1): TX FIFO occupancy.
- flush_pulse, out, 1: one cycle per siwu_n falling edge.
- err, out, 3: sticky bits {overlap, wr_when_full, rd_when_empty}.

Behaviour:
- Reset is asynchronous and active-low (rst_n).
  - Reset values: ft_d_oe=0, ft_d_out=0, ft_rxf_n=1, ft_txe_n=1, s_axis_tready=0, m_axis_tvalid=0, levels=0, flush_pulse=0, err=0.
  - Both FIFOs empty; both FSMs in IDLE.
  - Asserting reset mid-transaction drops the in-flight byte and releases the bus immediately (asynchronous clear of ft_d_oe).
- Input synchronization:
  - ft_rd_n, ft_wr_n and ft_siwu_n pass through 2-FF synchronizers; their reset value is 1.
  - ft_d_in is delayed two stages so it stays aligned with synchronized wr_n.
  - Edges are detected on the synchronized copies.
- RX FIFO (PC→FPGA):
  - s_axis_tready = !rx_full.
  - Push when tvalid && tready.
- Read FSM, states R_IDLE, R_WAIT, R_DRIVE, R_PRE:
  - ft_rxf_n = rx_empty || state != R_IDLE.
  - R_IDLE: on sync rd fall with rxf_n=0, go to R_WAIT and load the counter with RD_LATENCY-1.
    - If rd falls while rxf_n=1: set err[0], stay in R_IDLE, no drive.
  - R_WAIT: count down; at 0 go to R_DRIVE, set ft_d_oe=1, ft_d_out=rx head.
    - If rd rises before the count expires: abort to R_PRE with no pop.
  - R_DRIVE: hold oe and data while rd_n stays low. On sync rd rise: pop the RX FIFO, oe=0, go to R_PRE.
  - R_PRE: hold for RXF_PRECHARGE cycles, then return to R_IDLE.
- TX FIFO (FPGA→PC):
  - m_axis_tvalid = !tx_empty; tdata = head.
  - Pop when tvalid && tready.
- Write FSM, states W_IDLE, W_ACTIVE, W_PRE:
  - ft_txe_n = tx_full || state != W_IDLE.
  - W_IDLE: on sync wr fall with txe_n=0, go to W_ACTIVE.
    - If wr falls while txe_n=1: set err[1] and drop the write.
  - W_ACTIVE: on sync wr rise, push the delayed ft_d_in sampled in the last wr-low cycle, then go to W_PRE.
  - W_PRE: hold for TXE_PRECHARGE cycles, then return to W_IDLE.
- Overlap: if sync rd_n and sync wr_n are low in the same cycle, set err[2]. Both FSMs continue independently.
- Simultaneous push and pop on one FIFO: both occur and the level is unchanged. Pop from empty or push into full is impossible by construction.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Levels are updated registered, one cycle after the handshake.
- flush_pulse: asserted for one cycle on a sync siwu_n falling edge. It has no effect on the FIFOs.
- err bits clear only on reset.

Decomposition:
- Package ft245_model_pkg holds:
  - rd_state_t (R_IDLE, R_WAIT, R_DRIVE, R_PRE).
  - wr_state_t (W_IDLE, W_ACTIVE, W_PRE).
  - ERR_RD_EMPTY=0, ERR_WR_FULL=1, ERR_OVERLAP=2.
- One sub-module, ft245_byte_fifo (DEPTH param, push/pop/full/empty/level, async active-low reset), instantiated twice.

Test Plan:
- Push 0xA5 on s_axis, then pulse rd_n low for 10 cycles:
  - rxf_n falls 1 cycle after the push.
  - ft_d_oe=1 with d_out=0xA5 exactly 2+RD_LATENCY cycles after rd_n falls.
  - oe drops after the sync'd rise; rxf_n stays high 4 cycles, then stays high because the FIFO is empty; rx_level=0.
- Master writes 0x3C with wr_n low for 5 cycles:
  - txe_n goes high for the precharge.
  - m_axis presents 0x3C; after tready, tx_level=0.
- Write 16 bytes with m_axis_tready=0:
  - txe_n stays high after the 16th write.
  - A 17th wr_n pulse sets err[1]; tx_level remains 16.
- rd_n pulse with the RX FIFO empty:
  - err[0]=1, ft_d_oe never asserts.
- rd_n and wr_n held low together:
  - err[2]=1; the read still returns the head byte and the write is still captured.
- Assert rst_n low while in R_DRIVE:
  - ft_d_oe=0 the same cycle (asynchronously); all levels are 0 and rxf_n=1 after release.

Source files
------------

// File: rtl/ft245_model_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ft245_model_pkg
// Purpose  : Shared types and constants for the FT245 device model.
//            Holds the read/write FSM state encodings and the bit positions
//            of the sticky error vector.
// Revision : 1.0 - initial release
// ============================================================================
package ft245_model_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_DRIVE = 2'd2,
    R_PRE   = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_PRE    = 2'd2
  } wr_state_t;

  localparam int ERR_RD_EMPTY = 0;
  localparam int ERR_WR_FULL  = 1;
  localparam int ERR_OVERLAP  = 2;

endpackage
`default_nettype wire

// File: rtl/ft245_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ft245_byte_fifo
// Purpose  : Byte-wide synchronous FIFO with registered occupancy count.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            push_i, din_i   - write strobe and data
//            pop_i           - read strobe (head advances)
//            dout_o          - current head byte
//            full_o, empty_o - status derived from the occupancy count
//            level_o         - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module ft245_byte_fifo
  import ft245_model_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [7:0]                 din_i,
  input  logic                       pop_i,
  output logic [7:0]                 dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [LW-1:0] level_q;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/ft245_device_model.sv
`default_nettype none
// ============================================================================
// Module   : ft245_device_model
// Purpose  : Synthesizable stand-in for the FT2232H asynchronous 245-FIFO
//            interface. Answers master read/write strobes from two byte
//            FIFOs that are fed/drained through AXI-stream host ports.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            ft_rd_n/ft_wr_n/ft_siwu_n   - master strobes (asynchronous)
//            ft_d_in / ft_d_out, ft_d_oe - shared data bus halves
//            ft_rxf_n / ft_txe_n         - byte-available / space-available
//            s_axis_*                    - PC->FPGA bytes (RX FIFO input)
//            m_axis_*                    - FPGA->PC bytes (TX FIFO output)
//            rx_level / tx_level         - FIFO occupancies
//            flush_pulse                 - one cycle per siwu_n fall
//            err                         - sticky {overlap, wr_full, rd_empty}
// Revision : 1.0 - initial release
// ============================================================================
module ft245_device_model
  import ft245_model_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int RD_LATENCY    = 3,
  parameter int RXF_PRECHARGE = 4,
  parameter int TXE_PRECHARGE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ft_rd_n,
  input  logic                       ft_wr_n,
  input  logic                       ft_siwu_n,
  input  logic [7:0]                 ft_d_in,
  output logic [7:0]                 ft_d_out,
  output logic                       ft_d_oe,
  output logic                       ft_rxf_n,
  output logic                       ft_txe_n,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic [$clog2(DEPTH+1)-1:0] tx_level,
  output logic                       flush_pulse,
  output logic [2:0]                 err
);

  localparam int RD_CNT_MAX = (RD_LATENCY > RXF_PRECHARGE) ? RD_LATENCY : RXF_PRECHARGE;
  localparam int RCW        = $clog2(RD_CNT_MAX + 1);
  localparam int WCW        = $clog2(TXE_PRECHARGE + 1);

  // ---------------- strobe synchronizers and edge detection ----------------
  logic [1:0] rd_sync_q, wr_sync_q, siwu_sync_q;
  logic       rd_prev_q, wr_prev_q, siwu_prev_q;
  logic [7:0] d_pipe1_q, d_pipe2_q;
  logic       alive_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q   <= 2'b11;
      wr_sync_q   <= 2'b11;
      siwu_sync_q <= 2'b11;
      rd_prev_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
      siwu_prev_q <= 1'b1;
      d_pipe1_q   <= '0;
      d_pipe2_q   <= '0;
      alive_q     <= 1'b0;
    end else begin
      rd_sync_q   <= {rd_sync_q[0], ft_rd_n};
      wr_sync_q   <= {wr_sync_q[0], ft_wr_n};
      siwu_sync_q <= {siwu_sync_q[0], ft_siwu_n};
      rd_prev_q   <= rd_sync_q[1];
      wr_prev_q   <= wr_sync_q[1];
      siwu_prev_q <= siwu_sync_q[1];
      d_pipe1_q   <= ft_d_in;
      d_pipe2_q   <= d_pipe1_q;
      alive_q     <= 1'b1;
    end
  end

  logic rd_s, wr_s;
  logic rd_fall, rd_rise, wr_fall, wr_rise;
  assign rd_s    = rd_sync_q[1];
  assign wr_s    = wr_sync_q[1];
  assign rd_fall =  rd_prev_q & ~rd_s;
  assign rd_rise = ~rd_prev_q &  rd_s;
  assign wr_fall =  wr_prev_q & ~wr_s;
  assign wr_rise = ~wr_prev_q &  wr_s;
  assign flush_pulse = siwu_prev_q & ~siwu_sync_q[1];

  // ---------------- FIFOs ----------------
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic [7:0] wr_data_q;

  // Host side looks not-ready until the first clock after reset release.
  assign s_axis_tready = alive_q & ~rx_full;
  assign rx_push       = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = ~tx_empty;
  assign m_axis_tdata  = tx_head;
  assign tx_pop        = m_axis_tvalid & m_axis_tready;

  ft245_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .din_i(s_axis_tdata),
    .pop_i(rx_pop), .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty),
    .level_o(rx_level)
  );

  ft245_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .din_i(wr_data_q),
    .pop_i(tx_pop), .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty),
    .level_o(tx_level)
  );

  // ---------------- read FSM ----------------
  rd_state_t      rd_state_q, rd_state_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic           rd_valid;

  assign ft_rxf_n = rx_empty | (rd_state_q != R_IDLE);
  // The counter's final WAIT cycle already presents data, so the bus is
  // valid exactly RD_LATENCY cycles after the synchronized fall.
  assign rd_valid = (rd_state_q == R_DRIVE) || ((rd_state_q == R_WAIT) && (rd_cnt_q == '0));
  assign ft_d_oe  = rd_valid;
  assign ft_d_out = rd_valid ? rx_head : 8'h00;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rx_pop     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_fall && !ft_rxf_n) begin
          rd_state_d = R_WAIT;
          rd_cnt_d   = RCW'(RD_LATENCY - 1);
        end
      end
      R_WAIT: begin
        if (rd_rise) begin
          // A rise in the data-valid cycle completes the read; earlier aborts.
          rx_pop     = (rd_cnt_q == '0);
          rd_state_d = R_PRE;
          rd_cnt_d   = RCW'(RXF_PRECHARGE - 1);
        end else if (rd_cnt_q == '0) begin
          rd_state_d = R_DRIVE;
        end else begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
      end
      R_DRIVE: begin
        if (rd_rise) begin
          rx_pop     = 1'b1;
          rd_state_d = R_PRE;
          rd_cnt_d   = RCW'(RXF_PRECHARGE - 1);
        end
      end
      R_PRE: begin
        if (rd_cnt_q == '0) rd_state_d = R_IDLE;
        else                rd_cnt_d   = rd_cnt_q - 1'b1;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // ---------------- write FSM ----------------
  wr_state_t      wr_state_q, wr_state_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;

  assign ft_txe_n = ~alive_q | tx_full | (wr_state_q != W_IDLE);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    tx_push    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_fall && !ft_txe_n) wr_state_d = W_ACTIVE;
      end
      W_ACTIVE: begin
        if (wr_rise) begin
          tx_push    = 1'b1;
          wr_state_d = W_PRE;
          wr_cnt_d   = WCW'(TXE_PRECHARGE - 1);
        end
      end
      W_PRE: begin
        if (wr_cnt_q == '0) wr_state_d = W_IDLE;
        else                wr_cnt_d   = wr_cnt_q - 1'b1;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // ---------------- state, captured write byte, sticky errors ----------------
  logic [2:0] err_q, err_d;

  always_comb begin
    err_d               = err_q;
    err_d[ERR_RD_EMPTY] = err_q[ERR_RD_EMPTY] | (rd_fall & ft_rxf_n);
    err_d[ERR_WR_FULL]  = err_q[ERR_WR_FULL]  | (wr_fall & ft_txe_n);
    err_d[ERR_OVERLAP]  = err_q[ERR_OVERLAP]  | (~rd_s & ~wr_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= '0;
      wr_data_q  <= '0;
      err_q      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      // Tracks the bus while wr is low, so it holds the last wr-low byte at the rise.
      if (!wr_s) wr_data_q <= d_pipe2_q;
    end
  end

  assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ft245_device_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_device_model
// Purpose  : Directed self-checking bench for ft245_device_model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_device_model;

  localparam int DEPTH = 16;
  localparam int RD_LATENCY = 3;
  localparam int RXF_PRECHARGE = 4;
  localparam int TXE_PRECHARGE = 4;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          ft_rd_n, ft_wr_n, ft_siwu_n;
  logic [7:0]    ft_d_in, ft_d_out;
  logic          ft_d_oe, ft_rxf_n, ft_txe_n;
  logic [7:0]    s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tready;
  logic [LW-1:0] rx_level, tx_level;
  logic          flush_pulse;
  logic [2:0]    err;

  int checks = 0;
  int errors = 0;

  ft245_device_model #(
    .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY),
    .RXF_PRECHARGE(RXF_PRECHARGE), .TXE_PRECHARGE(TXE_PRECHARGE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_siwu_n(ft_siwu_n),
    .ft_d_in(ft_d_in), .ft_d_out(ft_d_out), .ft_d_oe(ft_d_oe),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rx_level(rx_level), .tx_level(tx_level), .flush_pulse(flush_pulse), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b);
    ft_wr_n = 1'b0; ft_d_in = b;
    repeat (3) tick();
    ft_wr_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_siwu_n = 1'b1; ft_d_in = 8'h00;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    repeat (3) tick();
    checks++; if (ft_d_oe !== 1'b0)       begin errors++; $display("FAIL reset_oe: got %b want 0", ft_d_oe); end
    checks++; if (ft_d_out !== 8'h00)     begin errors++; $display("FAIL reset_dout: got %h want 00", ft_d_out); end
    checks++; if (ft_rxf_n !== 1'b1)      begin errors++; $display("FAIL reset_rxf: got %b want 1", ft_rxf_n); end
    checks++; if (ft_txe_n !== 1'b1)      begin errors++; $display("FAIL reset_txe: got %b want 1", ft_txe_n); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if ({rx_level, tx_level} !== '0) begin errors++; $display("FAIL reset_levels: got %0d/%0d want 0/0", rx_level, tx_level); end
    checks++; if ({flush_pulse, err} !== 4'b0) begin errors++; $display("FAIL reset_flush_err: got %b/%b want 0/000", flush_pulse, err); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (ft_txe_n !== 1'b0 || s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: txe_n %b tready %b want 0/1", ft_txe_n, s_axis_tready); end
  endtask

  task automatic test_rd_empty();
    logic oe_seen = 1'b0;
    ft_rd_n = 1'b0;
    for (int n = 1; n <= 6; n++) begin tick(); if (ft_d_oe) oe_seen = 1'b1; end
    ft_rd_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin tick(); if (ft_d_oe) oe_seen = 1'b1; end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rd_empty_oe: got oe seen %b want 0", oe_seen); end
    checks++; if (err !== 3'b001)   begin errors++; $display("FAIL rd_empty_err: got %b want 001", err); end
  endtask

  task automatic test_read();
    int first_oe = -1, oe_drop = -1, rxf_fall = -1;
    logic [7:0] got = 8'h00;
    tick();
    checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL read_rxf_before: got %b want 1", ft_rxf_n); end
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5;
    tick();
    s_axis_tvalid = 1'b0;
    checks++; if (ft_rxf_n !== 1'b0 || rx_level !== LW'(1)) begin errors++; $display("FAIL read_after_push: rxf_n %b level %0d want 0/1", ft_rxf_n, rx_level); end
    ft_rd_n = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (ft_d_oe && first_oe < 0) begin first_oe = n; got = ft_d_out; end
    end
    checks++; if (first_oe != 2 + RD_LATENCY) begin errors++; $display("FAIL read_latency: got %0d want %0d", first_oe, 2 + RD_LATENCY); end
    checks++; if (got !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", got); end
    ft_rd_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (!ft_d_oe && oe_drop < 0) oe_drop = n;
      if (!ft_rxf_n && rxf_fall < 0) rxf_fall = n;
      s_axis_tvalid = 1'b0;
      if (n == 3) begin
        checks++; if (rx_level !== '0) begin errors++; $display("FAIL read_level_after_pop: got %0d want 0", rx_level); end
        // Queue a second byte during precharge; rxf_n must stay high until it ends.
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h5A;
      end
    end
    checks++; if (oe_drop != 3) begin errors++; $display("FAIL read_oe_drop: got %0d want 3", oe_drop); end
    checks++; if (rxf_fall != 3 + RXF_PRECHARGE) begin errors++; $display("FAIL read_precharge: got %0d want %0d", rxf_fall, 3 + RXF_PRECHARGE); end
  endtask

  task automatic test_write();
    int txe_back = -1;
    ft_wr_n = 1'b0; ft_d_in = 8'h3C;
    repeat (5) tick();
    checks++; if (ft_txe_n !== 1'b1) begin errors++; $display("FAIL write_txe_active: got %b want 1", ft_txe_n); end
    ft_wr_n = 1'b1; ft_d_in = 8'hFF;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (!ft_txe_n && txe_back < 0) txe_back = n;
      if (n == 3) begin
        checks++; if (tx_level !== LW'(1) || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h3C) begin
          errors++; $display("FAIL write_capture: level %0d tvalid %b data %h want 1/1/3c", tx_level, m_axis_tvalid, m_axis_tdata);
        end
      end
    end
    checks++; if (txe_back != 3 + TXE_PRECHARGE) begin errors++; $display("FAIL write_precharge: got %0d want %0d", txe_back, 3 + TXE_PRECHARGE); end
    m_axis_tready = 1'b1; tick(); m_axis_tready = 1'b0;
    checks++; if (tx_level !== '0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL write_drain: level %0d tvalid %b want 0/0", tx_level, m_axis_tvalid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      do_write(8'(8'h10 + i));
      if (i == DEPTH - 2) begin
        checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL fill_txe_almost: got %b want 0", ft_txe_n); end
      end
    end
    checks++; if (ft_txe_n !== 1'b1 || tx_level !== LW'(DEPTH)) begin errors++; $display("FAIL fill_full: txe_n %b level %0d want 1/%0d", ft_txe_n, tx_level, DEPTH); end
    do_write(8'hEE);
    checks++; if (err !== 3'b011) begin errors++; $display("FAIL fill_err: got %b want 011", err); end
    checks++; if (tx_level !== LW'(DEPTH)) begin errors++; $display("FAIL fill_level_kept: got %0d want %0d", tx_level, DEPTH); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL fill_order[%0d]: valid %b data %h want 1/%h", i, m_axis_tvalid, m_axis_tdata, 8'(8'h10 + i));
      end
      tick();
    end
    m_axis_tready = 1'b0;
    checks++; if (tx_level !== '0) begin errors++; $display("FAIL fill_drained: got %0d want 0", tx_level); end
  endtask

  task automatic test_overlap();
    logic [7:0] got = 8'h00;
    logic seen = 1'b0;
    ft_rd_n = 1'b0; ft_wr_n = 1'b0; ft_d_in = 8'h77;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (ft_d_oe && !seen) begin seen = 1'b1; got = ft_d_out; end
    end
    ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_d_in = 8'h00;
    repeat (10) tick();
    checks++; if (err[2] !== 1'b1) begin errors++; $display("FAIL overlap_err: got %b want 1xx", err); end
    checks++; if (seen !== 1'b1 || got !== 8'h5A) begin errors++; $display("FAIL overlap_read: seen %b data %h want 1/5a", seen, got); end
    checks++; if (rx_level !== '0 || tx_level !== LW'(1) || m_axis_tdata !== 8'h77) begin
      errors++; $display("FAIL overlap_write: rx %0d tx %0d data %h want 0/1/77", rx_level, tx_level, m_axis_tdata);
    end
    m_axis_tready = 1'b1; tick(); m_axis_tready = 1'b0;
  endtask

  task automatic test_flush();
    int first = -1, cnt = 0;
    ft_siwu_n = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (flush_pulse) begin cnt++; if (first < 0) first = n; end
      if (n == 3) ft_siwu_n = 1'b1;
    end
    checks++; if (cnt != 1 || first != 2) begin errors++; $display("FAIL flush_pulse: count %0d at %0d want 1 at 2", cnt, first); end
    checks++; if (rx_level !== '0 || tx_level !== '0) begin errors++; $display("FAIL flush_levels: rx %0d tx %0d want 0/0", rx_level, tx_level); end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hC3;
    tick();
    s_axis_tvalid = 1'b0;
    ft_rd_n = 1'b0;
    while (!ft_d_oe && waited < 12) begin tick(); waited++; end
    checks++; if (ft_d_oe !== 1'b1 || ft_d_out !== 8'hC3) begin errors++; $display("FAIL midrst_drive: oe %b data %h want 1/c3", ft_d_oe, ft_d_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ft_d_oe !== 1'b0 || ft_d_out !== 8'h00) begin errors++; $display("FAIL midrst_async: oe %b data %h want 0/00", ft_d_oe, ft_d_out); end
    tick();
    ft_rd_n = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (rx_level !== '0 || tx_level !== '0 || ft_rxf_n !== 1'b1) begin
      errors++; $display("FAIL midrst_after: rx %0d tx %0d rxf_n %b want 0/0/1", rx_level, tx_level, ft_rxf_n);
    end
    checks++; if (err !== 3'b000 || ft_d_oe !== 1'b0) begin errors++; $display("FAIL midrst_clear: err %b oe %b want 000/0", err, ft_d_oe); end
  endtask

  initial begin
    test_reset();
    test_rd_empty();
    test_read();
    test_write();
    test_fill();
    test_overlap();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
